// File: rtl/detect_mon_pkg.sv
// Shared definitions for the detect-pulse monitor: FSM encodings and default widths.
package detect_mon_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;

endpackage

// File: rtl/detect_pulse_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: clr, then load1, then inc; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every signal driven in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = W'(1);
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/detect_pulse_monitor.sv
// Health monitor for a sequence detector: counts Mealy and delayed detect pulses,
// checks that y_delay tracks y_mealy one cycle late, and measures inter-detection gaps.
module detect_pulse_monitor
  import detect_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             y_mealy,
  input  logic             y_delay,
  output logic [CNT_W-1:0] mealy_count,
  output logic [CNT_W-1:0] delay_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid,
  output logic [1:0]       state
);

  logic [1:0]       state_q, state_d;
  logic             m_q, m_d;
  logic             m_valid_q, m_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [GAP_W-1:0] last_gap_q, last_gap_d;
  logic             gap_valid_q, gap_valid_d;
  logic [GAP_W-1:0] gap_cnt;

  logic in_wait, in_meas;
  logic active, chk_fail, gap_hit, gap_load, gap_inc;

  // clear discards any event sampled on the same edge
  assign active   = en && !clear;
  assign chk_fail = active && m_valid_q && (y_delay != m_q);
  assign gap_hit  = active && in_meas && y_mealy;
  assign gap_load = active && (in_wait || in_meas) && y_mealy;
  assign gap_inc  = active && in_meas;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = en ? ST_WAIT_FIRST : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       if (en) state_d = ST_WAIT_FIRST;
        ST_WAIT_FIRST: begin
          if (!en)          state_d = ST_IDLE;
          else if (y_mealy) state_d = ST_MEASURE;
        end
        ST_MEASURE:    if (!en) state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_wait = (state_q == ST_WAIT_FIRST);
    in_meas = (state_q == ST_MEASURE);
  end

  // ---------------- result registers ----------------
  always_comb begin
    m_d         = m_q;
    m_valid_d   = m_valid_q;
    mismatch_d  = mismatch_q;
    last_gap_d  = last_gap_q;
    gap_valid_d = 1'b0;
    if (clear) begin
      m_d        = 1'b0;
      m_valid_d  = 1'b0;
      mismatch_d = 1'b0;
      last_gap_d = '0;
    end else begin
      // m_valid drops while disabled so the first re-enabled edge is never checked
      m_valid_d = en;
      if (en)       m_d         = y_mealy;
      if (chk_fail) mismatch_d  = 1'b1;
      if (gap_hit) begin
        last_gap_d  = gap_cnt;
        gap_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q         <= 1'b0;
      m_valid_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      last_gap_q  <= '0;
      gap_valid_q <= 1'b0;
    end else begin
      m_q         <= m_d;
      m_valid_q   <= m_valid_d;
      mismatch_q  <= mismatch_d;
      last_gap_q  <= last_gap_d;
      gap_valid_q <= gap_valid_d;
    end
  end

  // ---------------- counters ----------------
  sat_counter #(.W(CNT_W)) u_mealy_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active && y_mealy),
    .clr   (clear),
    .load1 (1'b0),
    .count (mealy_count)
  );

  sat_counter #(.W(CNT_W)) u_delay_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active && y_delay),
    .clr   (clear),
    .load1 (1'b0),
    .count (delay_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (chk_fail),
    .clr   (clear),
    .load1 (1'b0),
    .count (err_count)
  );

  // gap_cnt equals t1 - t0 at the edge that samples the second pulse
  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (gap_inc),
    .clr   (clear),
    .load1 (gap_load),
    .count (gap_cnt)
  );

  assign mismatch  = mismatch_q;
  assign last_gap  = last_gap_q;
  assign gap_valid = gap_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_detect_pulse_monitor.sv
// Directed bench for detect_pulse_monitor: expected gaps go into a scoreboard queue
// that a negedge monitor drains on gap_valid; counts and state are checked directly.
module tb_detect_pulse_monitor;

  logic clk = 1'b0;
  logic reset;
  logic en, clear, y_mealy, y_delay;
  logic [7:0] mealy_count, delay_count, err_count, last_gap;
  logic       mismatch, gap_valid;
  logic [1:0] state;

  logic en_s, clear_s, ym_s, yd_s;
  logic [1:0] mealy_count_s, delay_count_s, err_count_s;
  logic [2:0] last_gap_s;
  logic       mismatch_s, gap_valid_s;
  logic [1:0] state_s;

  int n_checks = 0;
  int n_errors = 0;
  int exp_gap_q[$];
  int exp_g;

  always #5 clk = ~clk;

  detect_pulse_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .y_mealy     (y_mealy),
    .y_delay     (y_delay),
    .mealy_count (mealy_count),
    .delay_count (delay_count),
    .err_count   (err_count),
    .mismatch    (mismatch),
    .last_gap    (last_gap),
    .gap_valid   (gap_valid),
    .state       (state)
  );

  detect_pulse_monitor #(.CNT_W(2), .GAP_W(3)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .en          (en_s),
    .clear       (clear_s),
    .y_mealy     (ym_s),
    .y_delay     (yd_s),
    .mealy_count (mealy_count_s),
    .delay_count (delay_count_s),
    .err_count   (err_count_s),
    .mismatch    (mismatch_s),
    .last_gap    (last_gap_s),
    .gap_valid   (gap_valid_s),
    .state       (state_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic m, input logic d);
    y_mealy = m;
    y_delay = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_s(input logic m);
    ym_s = m;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every gap_valid pulse must match the oldest expected gap.
  always @(negedge clk) begin
    if (reset && gap_valid) begin
      if (exp_gap_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL gap_valid_unexpected: got last_gap=%0d, expected no gap_valid (t=%0t)",
                 last_gap, $time);
      end else begin
        exp_g = exp_gap_q.pop_front();
        check("last_gap_on_valid", 32'(last_gap), 32'(exp_g));
      end
    end
  end

  // Healthy "100" detector response to x = 1,0,0,1,0,0,1,0,0 plus the trailing delayed pulse.
  logic tv_m [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  logic tv_d [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    reset = 1'b1; en = 1'b1; clear = 1'b0; y_mealy = 1'b0; y_delay = 1'b0;
    en_s = 1'b0; clear_s = 1'b0; ym_s = 1'b0; yd_s = 1'b0;

    // Reset takes effect before any clock edge
    #2 reset = 1'b0;
    #1;
    check("rst_mealy_count", 32'(mealy_count), 0);
    check("rst_err_count",   32'(err_count),   0);
    check("rst_mismatch",    32'(mismatch),    0);
    check("rst_last_gap",    32'(last_gap),    0);
    check("rst_gap_valid",   32'(gap_valid),   0);
    check("rst_state",       32'(state),       0);
    #17 reset = 1'b1;

    // Healthy traffic: three detections three cycles apart
    for (int i = 0; i < 10; i++) begin
      if (i == 5 || i == 8) exp_gap_q.push_back(3);
      step(tv_m[i], tv_d[i]);
    end
    check("t1_mealy_count", 32'(mealy_count), 3);
    check("t1_delay_count", 32'(delay_count), 3);
    check("t1_err_count",   32'(err_count),   0);
    check("t1_mismatch",    32'(mismatch),    0);
    check("t1_last_gap",    32'(last_gap),    3);
    check("t1_state",       32'(state),       2);
    check("t1_gaps_seen",   32'(exp_gap_q.size()), 0);

    // Spurious y_delay with no preceding y_mealy
    step(0, 0);
    step(0, 1);
    check("t2_mismatch",    32'(mismatch),    1);
    check("t2_err_count",   32'(err_count),   1);
    check("t2_delay_count", 32'(delay_count), 4);
    exp_gap_q.push_back(4);
    step(1, 0);
    step(0, 1);
    step(0, 0);
    check("t2_err_hold",      32'(err_count),   1);
    check("t2_mismatch_hold", 32'(mismatch),    1);
    check("t2_mealy_count",   32'(mealy_count), 4);
    check("t2_delay_count5",  32'(delay_count), 5);
    check("t2_last_gap",      32'(last_gap),    4);

    // Clear coinciding with a detect pulse discards the pulse
    clear = 1'b1;
    step(1, 1);
    clear = 1'b0;
    check("clr_mealy_count", 32'(mealy_count), 0);
    check("clr_delay_count", 32'(delay_count), 0);
    check("clr_err_count",   32'(err_count),   0);
    check("clr_mismatch",    32'(mismatch),    0);
    check("clr_last_gap",    32'(last_gap),    0);
    check("clr_state",       32'(state),       1);
    step(1, 0);
    check("clr_next_state",     32'(state),       2);
    check("clr_next_mealy",     32'(mealy_count), 1);
    check("clr_next_gap_valid", 32'(gap_valid),   0);
    step(0, 1);

    // Disabled window between two pulses: results hold, no gap across it
    en = 1'b0;
    step(0, 0);
    step(1, 1);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    check("dis_state",       32'(state),       0);
    check("dis_mealy_hold",  32'(mealy_count), 1);
    check("dis_delay_hold",  32'(delay_count), 1);
    check("dis_err_hold",    32'(err_count),   0);
    en = 1'b1;
    step(0, 0);
    check("reen_state_wait", 32'(state), 1);
    step(1, 0);
    check("reen_state_meas", 32'(state),       2);
    check("reen_mealy",      32'(mealy_count), 2);
    check("reen_gap_valid",  32'(gap_valid),   0);
    check("reen_last_gap",   32'(last_gap),    0);
    step(0, 1);
    check("reen_err_count",  32'(err_count),   0);
    check("reen_delay",      32'(delay_count), 2);

    // Asynchronous reset between edges while measuring
    #3 reset = 1'b0;
    #1;
    check("arst_mealy_count", 32'(mealy_count), 0);
    check("arst_delay_count", 32'(delay_count), 0);
    check("arst_err_count",   32'(err_count),   0);
    check("arst_mismatch",    32'(mismatch),    0);
    check("arst_last_gap",    32'(last_gap),    0);
    check("arst_gap_valid",   32'(gap_valid),   0);
    check("arst_state",       32'(state),       0);
    #2 reset = 1'b1;

    // Narrow instance: CNT_W=2 saturation and GAP_W=3 gap clipping
    en_s = 1'b1;
    step_s(0);
    for (int i = 0; i < 5; i++) step_s(1);
    check("sat_mealy_count", 32'(mealy_count_s), 3);
    for (int i = 0; i < 9; i++) step_s(0);
    check("sat_err_count",   32'(err_count_s),   3);
    check("sat_mismatch",    32'(mismatch_s),    1);
    step_s(1);
    check("sat_last_gap",    32'(last_gap_s),    7);
    check("sat_gap_valid",   32'(gap_valid_s),   1);
    check("sat_mealy_hold",  32'(mealy_count_s), 3);
    check("sat_delay_count", 32'(delay_count_s), 0);
    step_s(0);
    check("sat_gap_valid_1cyc", 32'(gap_valid_s), 0);

    step(0, 0);
    step(0, 0);
    check("gaps_all_seen", 32'(exp_gap_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/detect_pulse_monitor.md
Name: detect_pulse_monitor

Overview:
- Downstream consumer of the sequence-detector outputs: samples the Mealy detect pulse `y_mealy` and the registered detect pulse `y_delay` on every clock.
- Counts detections on each path.
- Checks that `y_delay` equals `y_mealy` from the previous cycle, and flags any mismatch.
- Measures the interval in cycles between consecutive Mealy detections.
- Lets the lab bench and board LEDs report detector health without waveform inspection.

Parameters:
- CNT_W, default 8: width of the detection and error counters.
- GAP_W, default 8: width of the inter-detection gap counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  monitor enable; while 0 the block idles and holds its results.
- clear  input  1  synchronous clear of all results; takes priority over every other event.
- y_mealy  input  1  Mealy detect pulse from the upstream detector.
- y_delay  input  1  registered (one-cycle-delayed) detect pulse from the upstream detector.
- mealy_count  output  CNT_W  number of cycles in which `y_mealy` was sampled high; saturating.
- delay_count  output  CNT_W  number of cycles in which `y_delay` was sampled high; saturating.
- err_count  output  CNT_W  number of cycles in which the check `y_delay != m_q` failed; saturating.
- mismatch  output  1  sticky error flag.
- last_gap  output  GAP_W  cycles between the two most recent `y_mealy` samples; saturating.
- gap_valid  output  1  one-cycle pulse when `last_gap` updates.
- state  output  2  FSM state: IDLE=0, WAIT_FIRST=1, MEASURE=2.

Behaviour:
- Reset (`reset`=0, asynchronous): all outputs 0, state IDLE, internal `m_q`=0, `m_valid`=0, `gap_cnt`=0. Takes effect immediately, with no clock edge required.
- Sampling: inputs are observed only at the rising edge of `clk`. Combinational glitches on `y_mealy` between edges are ignored by design.
- `m_q` register: `m_q` <= `y_mealy` on every edge while `en`=1.
- `m_valid` flag: set on the first enabled edge. It is cleared while `en`=0 or on `clear`.
- Check (edges with `en`=1 and `m_valid`=1): if `y_delay` != `m_q`, then `err_count`+1 and `mismatch` <= 1. `mismatch` remains 1 until `clear` or reset.
- Counting (`en`=1): `mealy_count`+1 if `y_mealy`=1; `delay_count`+1 if `y_delay`=1.
- Saturation: all counters stop at all-ones and never wrap.
- FSM:
  - IDLE: if `en`=1, go to WAIT_FIRST.
  - WAIT_FIRST: if `en`=0, go to IDLE. If `y_mealy`=1, go to MEASURE and set `gap_cnt` <= 1.
  - MEASURE: if `en`=0, go to IDLE; `gap_cnt` and results are held. Otherwise `gap_cnt` increments each cycle, saturating at 2^GAP_W-1. If `y_mealy`=1: `last_gap` <= `gap_cnt`, `gap_valid`=1 on the following cycle, and `gap_cnt` <= 1.
- Gap definition: for pulses sampled at edges t0 and t1, `last_gap` = t1 - t0. It is clipped to 2^GAP_W-1.
- `gap_valid` is a registered pulse exactly 1 cycle wide. It is 0 in every other cycle.
- Clear (synchronous, `clear`=1): counters, `mismatch`, `last_gap`, `gap_cnt`, `m_q` and `m_valid` all go to 0. State goes to WAIT_FIRST if `en`=1, else IDLE. A simultaneous `y_mealy` or `y_delay` pulse is discarded.
- Re-enable after `en`=0: state goes IDLE → WAIT_FIRST. The first gap after re-enable is not measured across the disabled window.
- Upstream reset mid-stream: the monitor keeps running on its own reset. A pulse pattern broken by an upstream reset shows up only through `y_mealy`/`y_delay` as sampled; no special handling.
- Latency: every output reflects inputs sampled at the previous edge (1-cycle registered outputs).

Decomposition:
- Shared package `detect_mon_pkg`:
  - state encodings IDLE/WAIT_FIRST/MEASURE as 2-bit localparams;
  - default CNT_W and GAP_W.
- One natural sub-module, `sat_counter`:
  - parameterised width;
  - inputs: `inc`, `clr`, `load1`;
  - output: count;
  - saturating behaviour.
  - Instantiated four times: mealy, delay, err, gap.

Test Plan:
- Release reset at 20 ns with `en`=1, then drive `x` = 1,0,0,1,0,0,1,0,0 into a healthy upstream detector for the pattern "100" (three detections, 3 cycles apart) → `mealy_count`=3, `delay_count`=3, `err_count`=0, `mismatch`=0, `last_gap`=3, `gap_valid` pulsed twice, `state`=MEASURE.
- Force `y_delay`=1 for one cycle with no preceding `y_mealy` → the next cycle shows `mismatch`=1 and `err_count`=1. Both hold through later clean traffic until `clear`.
- CNT_W=2: five `y_mealy` pulses → `mealy_count`=3 (saturated, no wrap). GAP_W=3: two pulses 10 cycles apart → `last_gap`=7.
- Assert `reset`=0 asynchronously between clock edges while in MEASURE with nonzero counts → all outputs 0 before the next edge; `state`=IDLE.
- `clear`=1 in the same cycle as a `y_mealy` pulse → all counts 0, `last_gap`=0, `state`=WAIT_FIRST. The next pulse moves the FSM to MEASURE without producing `gap_valid`.
- `en`=0 for 5 cycles between two pulses, then `en`=1 → counts hold while disabled, `state` goes IDLE → WAIT_FIRST, and no `gap_valid` is produced for the pulse that spans the disabled window.
